// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory responder for the single-cycle ARM core.
//
// Serves the core's data port with a word RAM and three memory-mapped
// registers: a transmit FIFO drained over a valid/ready stream, a status
// register and a free-running cycle counter.
//
// Address map (byte addresses, a[1:0] ignored):
//   0x000-0x0FF  RAM (words at or above RAM_WORDS read 0, writes dropped)
//   0x100        TXDATA  write pushes wd into the FIFO, reads 0
//   0x104        STATUS  {20'b0, count[3:0], 5'b0, overflow, full, empty}
//                        write with wd[2]=1 clears overflow
//   0x108        CYCLES  free-running counter, write loads wd
//   other        reads 0, writes ignored
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  synchronous, active-high
//   we         in   1  write strobe (MemWrite)
//   a          in  32  byte address (DataAdr)
//   wd         in  32  write data (WriteData)
//   rd         out 32  read data (ReadData), combinational
//   out_valid  out  1  FIFO head valid
//   out_data   out 32  FIFO head word
//   out_ready  in   1  sink accepts head this cycle
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  // Storage (not reset)
  logic [31:0] ram_q  [RAM_WORDS];
  logic [31:0] fifo_q [FIFO_DEPTH];

  // Control state and next-state
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cyc_q, cyc_d;

  // Address decode
  logic          sel_ram_s, ram_hit_s, sel_tx_s, sel_stat_s, sel_cyc_s;
  logic [AW-1:0] ram_idx_s;
  logic          unused_s;

  assign sel_ram_s  = (a[31:8] == 24'h0);
  // Only the low RAM_WORDS words of the 256-byte window are backed.
  assign ram_hit_s  = sel_ram_s && ({1'b0, a[7:2]} < 7'(RAM_WORDS));
  assign ram_idx_s  = a[2 +: AW];
  assign sel_tx_s   = (a[31:2] == 30'h40);
  assign sel_stat_s = (a[31:2] == 30'h41);
  assign sel_cyc_s  = (a[31:2] == 30'h42);
  assign unused_s   = ^a[1:0];

  // FIFO handshake
  logic pop_s, push_req_s, push_ok_s, full_s, empty_s;
  logic [3:0] cnt4_s;

  assign empty_s    = (count_q == CW'(0));
  assign full_s     = (count_q == CW'(FIFO_DEPTH));
  assign out_valid  = !empty_s;
  assign out_data   = fifo_q[rptr_q];
  assign pop_s      = out_valid && out_ready;
  assign push_req_s = we && sel_tx_s;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok_s  = push_req_s && (!full_s || pop_s);
  assign cnt4_s     = 4'(count_q);

  // Next-state logic for pointers, count, overflow and cycle counter
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    cyc_d   = cyc_q;

    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end

    if (push_ok_s) begin
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end

    if (push_ok_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok_s && pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    // A new overflow wins over a same-cycle clear.
    if (push_req_s && !push_ok_s) begin
      ovf_d = 1'b1;
    end else if (we && sel_stat_s && wd[2]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (we && sel_cyc_s) begin
      cyc_d = wd;
    end else begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      cyc_q   <= 32'h0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_d;
    end
  end

  // RAM and FIFO storage writes, suppressed during reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (we && ram_hit_s) begin
        ram_q[ram_idx_s] <= wd;
      end
      if (push_ok_s) begin
        fifo_q[wptr_q] <= wd;
      end
    end
  end

  // Combinational read mux
  always_comb begin
    rd = 32'h0;
    if (ram_hit_s) begin
      rd = ram_q[ram_idx_s];
    end else if (sel_stat_s) begin
      rd = {20'h0, cnt4_s, 5'h0, ovf_q, full_s, empty_s};
    end else if (sel_cyc_s) begin
      rd = cyc_q;
    end else begin
      rd = 32'h0;
    end
  end

endmodule
